fifo_rd_stream_adapter: RTL and testbench

Sits directly downstream of the asynchronous FIFO's read port, in the read clock domain. It converts the FIFO's rd_en/rd_data/empty interface, whose read data has a fixed latency, into a valid/ready stream with full backpressure. It also frames the stream into packets of PKT_LEN words, marking each packet's final word with m_last. It prefetches from the FIFO using a credit counter so that no returning read data is ever dropped.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/stream_skid_buf.sv | 56 +++++
 rtl/fifo_rd_stream_adapter.sv | 86 ++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the FIFO read-side stream adapter.
package fifo_pkg;

  localparam int unsigned DEF_DW        = 16;
  localparam int unsigned DEF_RD_LAT    = 1;
  localparam int unsigned DEF_BUF_DEPTH = 4;
  localparam int unsigned DEF_PKT_LEN   = 8;
  localparam int unsigned DEF_PW        = 8;

  // Index width for a power-of-two buffer; never below 1 so slices stay legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Circular DW x DEPTH buffer with wrap-bit pointers; head is valid whenever occupancy is non-zero.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned  DW    = DEF_DW,
  parameter int unsigned  DEPTH = DEF_BUF_DEPTH,
  localparam int unsigned AW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [DW-1:0] head_o,
  output logic [AW:0]   occ_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          empty, full;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign valid_o = !empty;
  assign occ_o   = wr_ptr_q - rd_ptr_q;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: next-state defaults are assigned first so every path drives every signal and no latch appears.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i)          wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_i && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; head_o is forced to zero while empty so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns a fixed-latency FIFO read port into a valid/ready packet stream, issuing reads only against free buffer credit.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned RD_LAT    = DEF_RD_LAT,
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned PKT_LEN   = DEF_PKT_LEN,
  parameter int unsigned PW        = DEF_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [PW-1:0] pkt_count,
  output logic          busy
);

  localparam int unsigned AW = ptr_width(BUF_DEPTH);
  localparam int unsigned CW = AW + 2;

  logic [RD_LAT-1:0] lat_sr_q, lat_sr_d;
  logic [PW-1:0]     pkt_q, pkt_d;
  logic [AW:0]       occ;
  logic [CW-1:0]     inflight;
  logic              credit_ok, push, pop, last_word;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(lat_sr_q[i]);
  end

  // Words already buffered plus words still returning must leave room for one more.
  assign credit_ok  = ({1'b0, occ} + inflight) < CW'(BUF_DEPTH);
  assign fifo_rd_en = !rst && enable && !fifo_empty && credit_ok;
  assign push       = lat_sr_q[RD_LAT-1];
  assign pop        = m_valid && m_ready;

  always_comb begin
    lat_sr_d    = '0;
    lat_sr_d[0] = fifo_rd_en;
    for (int i = 1; i < RD_LAT; i++) lat_sr_d[i] = lat_sr_q[i-1];
  end

  assign last_word = (pkt_q == PW'(PKT_LEN - 1));

  always_comb begin
    pkt_d = pkt_q;
    if (pop) pkt_d = last_word ? '0 : pkt_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_sr_q <= '0;
      pkt_q    <= '0;
    end else begin
      lat_sr_q <= lat_sr_d;
      pkt_q    <= pkt_d;
    end
  end

  stream_skid_buf #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (fifo_rd_data),
    .pop_i       (pop),
    .valid_o     (m_valid),
    .head_o      (m_data),
    .occ_o       (occ)
  );

  assign m_last    = m_valid && last_word;
  assign pkt_count = pkt_q;
  assign busy      = (occ != '0) || (inflight != '0);

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: a latency-1 instance for framing/backpressure/gaps/reset and a latency-3 instance for drain and random ready.
module tb_fifo_rd_stream_adapter;

  localparam int DW = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- latency-1 instance ----------------
  logic          rst1, en1, empty1, rd_en1, valid1, ready1, last1, busy1;
  logic [DW-1:0] rdata1 = 16'hDEAD;
  logic [DW-1:0] data1;
  logic [PW-1:0] pkt1;
  int            rp1 = 0, wr1 = 0, gap_cnt = 0;
  logic          gap_en = 1'b0, gap_q = 1'b0;

  assign empty1 = (rp1 >= wr1) || gap_q;

  fifo_rd_stream_adapter #(.DW(DW), .RD_LAT(1), .BUF_DEPTH(4), .PKT_LEN(8), .PW(PW)) u_dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .fifo_empty(empty1), .fifo_rd_en(rd_en1),
    .fifo_rd_data(rdata1), .m_valid(valid1), .m_ready(ready1), .m_data(data1),
    .m_last(last1), .pkt_count(pkt1), .busy(busy1));

  // FIFO model: word at index i holds i+1; unread cycles return a poison value.
  always @(posedge clk) begin
    if (rd_en1) begin
      rdata1 <= 16'(rp1 + 1);
      rp1    <= rp1 + 1;
    end else begin
      rdata1 <= 16'hDEAD;
    end
    if (gap_en) begin
      if (gap_cnt == 2) begin
        gap_cnt <= 0;
        gap_q   <= ~gap_q;
      end else begin
        gap_cnt <= gap_cnt + 1;
      end
    end else begin
      gap_cnt <= 0;
      gap_q   <= 1'b0;
    end
  end

  int            idx1 = 0, pkt_exp1 = 0, gap_bubbles = 0;
  logic          hold1 = 1'b0;
  logic [DW-1:0] hold_data1 = '0;

  always @(negedge clk) begin
    if (rst1) begin
      idx1     = rp1;
      pkt_exp1 = 0;
      hold1    = 1'b0;
    end else begin
      check("m1_rd_en_while_empty", rd_en1 & empty1, 0);
      check("m1_pkt_count", pkt1, pkt_exp1);
      check("m1_last", last1, valid1 && (pkt_exp1 == 7));
      if (hold1) begin
        check("m1_hold_valid", valid1, 1);
        check("m1_hold_data", data1, hold_data1);
      end
      if (gap_en && !valid1) gap_bubbles++;
      if (valid1 && ready1) begin
        check("m1_data_order", data1, 16'(idx1 + 1));
        idx1++;
        pkt_exp1 = (pkt_exp1 == 7) ? 0 : pkt_exp1 + 1;
      end
      hold1      = valid1 && !ready1;
      hold_data1 = data1;
    end
  end

  // ---------------- latency-3 instance ----------------
  logic          rst3, en3, empty3, rd_en3, valid3, ready3, last3, busy3;
  logic [DW-1:0] d1 = 16'hBEEF, d2 = 16'hBEEF, d3 = 16'hBEEF;
  logic [DW-1:0] data3;
  logic [PW-1:0] pkt3;
  int            rp3 = 0, wr3 = 0;

  assign empty3 = (rp3 >= wr3);

  fifo_rd_stream_adapter #(.DW(DW), .RD_LAT(3), .BUF_DEPTH(4), .PKT_LEN(8), .PW(PW)) u_dut3 (
    .clk(clk), .rst(rst3), .enable(en3), .fifo_empty(empty3), .fifo_rd_en(rd_en3),
    .fifo_rd_data(d3), .m_valid(valid3), .m_ready(ready3), .m_data(data3),
    .m_last(last3), .pkt_count(pkt3), .busy(busy3));

  // FIFO model: word at index i holds 3*i+7, returned three cycles after the read.
  always @(posedge clk) begin
    if (rd_en3) begin
      d1  <= 16'(rp3 * 3 + 7);
      rp3 <= rp3 + 1;
    end else begin
      d1 <= 16'hBEEF;
    end
    d2 <= d1;
    d3 <= d2;
  end

  int            idx3 = 0, pkt_exp3 = 0;
  logic          hold3 = 1'b0;
  logic [DW-1:0] hold_data3 = '0;

  always @(negedge clk) begin
    if (rst3) begin
      idx3     = rp3;
      pkt_exp3 = 0;
      hold3    = 1'b0;
    end else begin
      check("m3_rd_en_while_empty", rd_en3 & empty3, 0);
      check("m3_pkt_count", pkt3, pkt_exp3);
      check("m3_last", last3, valid3 && (pkt_exp3 == 7));
      if (hold3) begin
        check("m3_hold_valid", valid3, 1);
        check("m3_hold_data", data3, hold_data3);
      end
      if (valid3 && ready3) begin
        check("m3_data_order", data3, 16'(idx3 * 3 + 7));
        idx3++;
        pkt_exp3 = (pkt_exp3 == 7) ? 0 : pkt_exp3 + 1;
      end
      hold3      = valid3 && !ready3;
      hold_data3 = data3;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst1 = 1'b1; en1 = 1'b1; ready1 = 1'b1; wr1 = 16;
    rst3 = 1'b1; en3 = 1'b0; ready3 = 1'b0; wr3 = 200;

    // Reset held three cycles with data available in the FIFO.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_rd_en", rd_en1, 0);
      check("rst_m_valid", valid1, 0);
      check("rst_pkt_count", pkt1, 0);
      check("rst_busy", busy1, 0);
      check("rst_m_data", data1, 0);
      check("rst_m_last", last1, 0);
    end

    rst1 = 1'b0;
    #1;
    check("first_rd_en", rd_en1, 1);
    check("first_m_valid", valid1, 0);
    step();
    check("fill_m_valid", valid1, 0);
    check("fill_busy", busy1, 1);

    // 16 words with no bubbles, packet ends on 0x0008 and 0x0010.
    step();
    for (int i = 0; i < 16; i++) begin
      check("stream_valid", valid1, 1);
      check("stream_data", data1, 16'(i + 1));
      check("stream_last", last1, (i % 8) == 7);
      step();
    end
    check("stream_idle_valid", valid1, 0);
    check("stream_idle_busy", busy1, 0);
    check("stream_idle_pkt", pkt1, 0);

    // Backpressure: stall ten cycles with 0x0012 at the head.
    wr1 = 48;
    #1;
    check("bp_rd_en_start", rd_en1, 1);
    step();
    step();
    check("bp_pre_data", data1, 16'h0011);
    step();
    ready1 = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_data", data1, 16'h0012);
      check("bp_hold_pkt", pkt1, 1);
      check("bp_rd_en", rd_en1, i < 2);
      check("bp_outstanding_le4", (rp1 - idx1) <= 4, 1);
      step();
    end
    check("bp_reads_issued", rp1, 21);
    ready1 = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_release_valid", valid1, 1);
      check("bp_release_data", data1, 16'(18 + i));
      step();
    end
    for (int i = 0; i < 100 && !(rp1 == wr1 && !busy1); i++) step();
    check("bp_drained", rp1 == wr1 && !busy1, 1);
    check("bp_words_out", idx1, 48);
    check("bp_pkt_end", pkt1, 0);

    // FIFO empty toggling every three cycles.
    gap_en = 1'b1;
    wr1 = 72;
    for (int i = 0; i < 400 && !(rp1 == wr1 && !busy1); i++) step();
    check("gap_drained", rp1 == wr1 && !busy1, 1);
    gap_en = 1'b0;
    step();
    step();
    check("gap_words_out", idx1, 72);
    check("gap_bubbles_seen", gap_bubbles > 0, 1);
    check("gap_pkt_end", pkt1, 0);

    // Reset pulse with three words buffered and one read in flight.
    wr1 = 84;
    #1;
    check("rp_rd_en", rd_en1, 1);
    step();
    step();
    check("rp_first_data", data1, 16'h0049);
    step();
    ready1 = 1'b0;
    step();
    step();
    check("rp_pre_data", data1, 16'h004A);
    check("rp_pre_pkt", pkt1, 1);
    check("rp_pre_reads", rp1, 77);
    check("rp_pre_busy", busy1, 1);
    rst1 = 1'b1;
    #1;
    check("rp_rd_en_in_rst", rd_en1, 0);
    step();
    rst1 = 1'b0;
    ready1 = 1'b1;
    #1;
    check("rp_post_valid", valid1, 0);
    check("rp_post_busy", busy1, 0);
    check("rp_post_pkt", pkt1, 0);
    check("rp_post_rd_en", rd_en1, 1);
    step();
    check("rp_refill_valid", valid1, 0);
    step();
    check("rp_refill_valid2", valid1, 1);
    check("rp_late_data_skipped", data1, 16'h004E);
    for (int i = 0; i < 100 && !(rp1 == wr1 && !busy1); i++) step();
    check("rp_drained", rp1 == wr1 && !busy1, 1);
    check("rp_words_out", idx1, 84);
    check("rp_pkt_partial", pkt1, 7);
    check("rp_last_idle", last1, 0);

    // Latency-3 instance: enable dropped with two reads in flight.
    rst3 = 1'b0;
    en3 = 1'b1;
    #1;
    check("l3_rd_en_c0", rd_en3, 1);
    step();
    check("l3_rd_en_c1", rd_en3, 1);
    step();
    en3 = 1'b0;
    #1;
    check("l3_rd_en_disabled", rd_en3, 0);
    check("l3_busy_inflight", busy3, 1);
    step();
    check("l3_valid_c3", valid3, 0);
    step();
    check("l3_valid_c4", valid3, 1);
    check("l3_data_c4", data3, 16'd7);
    step();
    check("l3_hold_c5", data3, 16'd7);
    ready3 = 1'b1;
    step();
    check("l3_valid_c6", valid3, 1);
    check("l3_data_c6", data3, 16'd10);
    check("l3_pkt_c6", pkt3, 1);
    step();
    check("l3_valid_c7", valid3, 0);
    check("l3_busy_c7", busy3, 0);
    check("l3_pkt_kept", pkt3, 2);

    // Random ready for the remaining words.
    en3 = 1'b1;
    for (int i = 0; i < 4000 && idx3 < 200; i++) begin
      ready3 = 1'($urandom_range(0, 1));
      step();
    end
    check("l3_words_out", idx3, 200);
    ready3 = 1'b1;
    for (int i = 0; i < 20 && busy3; i++) step();
    check("l3_idle_busy", busy3, 0);
    check("l3_idle_valid", valid3, 0);
    check("l3_pkt_end", pkt3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
